// File: rtl/tmu_burst_writer.sv
// TMU final stage: write-combines RGB565 pixels into a 32-byte line and emits 4-beat FML bursts.
// Optional TMU_BURST_WRITER_STATS_EN adds burst/pixel counters (ports bursts, pixels).
module tmu_burst_writer #(
    parameter int fml_depth    = 26,
    parameter int idle_timeout = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    output logic                 busy,
    input  logic                 pipe_stb_i,
    output logic                 pipe_ack_o,
    input  logic [15:0]          color,
    input  logic [fml_depth-2:0] dst_addr,
`ifdef TMU_BURST_WRITER_STATS_EN
    output logic [31:0]          bursts,
    output logic [31:0]          pixels,
`endif
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do
);

    localparam int TW = fml_depth - 5;
    localparam int IW = $clog2(idle_timeout + 1);

    typedef enum logic [2:0] {COLLECT, REQ, D0, D1, D2, D3} state_t;

    state_t           state_q, state_d;
    logic [15:0][15:0] data_q, data_d;
    logic [31:0]      en_q, en_d;
    logic [TW-1:0]    tag_q, tag_d;
    logic [IW-1:0]    idle_q, idle_d;

    logic [TW-1:0]    in_tag;
    logic [3:0]       in_slot;
    logic             empty, hit, accept;
    logic [1:0]       beat;
    logic             beat_vld;

    assign in_tag  = dst_addr[fml_depth-2:4];
    assign in_slot = dst_addr[3:0];
    assign empty   = ~|en_q;
    assign hit     = (tag_q == in_tag);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= COLLECT;
            data_q  <= '0;
            en_q    <= '0;
            tag_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            tag_q   <= tag_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        en_d    = en_q;
        tag_d   = tag_q;
        idle_d  = idle_q;
        accept  = 1'b0;
        case (state_q)
            COLLECT: begin
                accept = pipe_stb_i & (empty | hit);
                if (accept) begin
                    // tag reload is harmless on a hit since the tags already match
                    data_d[in_slot]              = color;
                    en_d[{in_slot, 1'b0} +: 2]   = 2'b11;
                    tag_d                        = in_tag;
                    idle_d                       = '0;
                end else if (pipe_stb_i && !empty) begin
                    state_d = REQ;
                    idle_d  = '0;
                end else if (!empty) begin
                    if (idle_q == IW'(idle_timeout - 1)) begin
                        state_d = REQ;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            REQ:     if (fml_ack) state_d = D0;
            D0:      state_d = D1;
            D1:      state_d = D2;
            D2:      state_d = D3;
            D3: begin
                state_d = COLLECT;
                en_d    = '0;
                idle_d  = '0;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        beat     = 2'd0;
        beat_vld = 1'b0;
        fml_sel  = '0;
        fml_do   = '0;
        case (state_q)
            D0:      begin beat_vld = 1'b1; beat = 2'd0; end
            D1:      begin beat_vld = 1'b1; beat = 2'd1; end
            D2:      begin beat_vld = 1'b1; beat = 2'd2; end
            D3:      begin beat_vld = 1'b1; beat = 2'd3; end
            default: ;
        endcase
        // big-endian lanes: lowest slot of the beat lands in the top halfword / sel[7:6]
        if (beat_vld) begin
            for (int j = 0; j < 4; j++) begin
                fml_do[63-16*j -: 16] = data_q[{beat, 2'(j)}];
                fml_sel[7-2*j]        = en_q[{beat, 2'(j), 1'b0}];
                fml_sel[6-2*j]        = en_q[{beat, 2'(j), 1'b1}];
            end
        end
    end

    assign pipe_ack_o = accept;
    assign fml_stb    = (state_q == REQ);
    assign fml_adr    = {tag_q, 5'b0};
    assign fml_we     = 1'b1;
    assign busy       = (state_q != COLLECT) | ~empty;

`ifdef TMU_BURST_WRITER_STATS_EN
    logic [31:0] bursts_q, pixels_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bursts_q <= '0;
            pixels_q <= '0;
        end else begin
            if (state_q == D3) bursts_q <= bursts_q + 32'd1;
            if (accept)        pixels_q <= pixels_q + 32'd1;
        end
    end

    assign bursts = bursts_q;
    assign pixels = pixels_q;
`endif

endmodule

// File: tb/tb_tmu_burst_writer.sv
// Scoreboard bench for tmu_burst_writer: stimulus queues expected bursts, an FML slave monitor checks them.
module tb_tmu_burst_writer;

    localparam int FD = 26;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          busy;
    logic          pipe_stb_i = 1'b0;
    logic          pipe_ack_o;
    logic [15:0]   color = '0;
    logic [FD-2:0] dst_addr = '0;
    logic [FD-1:0] fml_adr;
    logic          fml_stb, fml_we, fml_ack;
    logic [7:0]    fml_sel;
    logic [63:0]   fml_do;
    logic          mon_ack = 1'b0, st_ack = 1'b0;
`ifdef TMU_BURST_WRITER_STATS_EN
    logic [31:0]   bursts, pixels;
`endif

    assign fml_ack = mon_ack | st_ack;

    always #5 sys_clk = ~sys_clk;

    tmu_burst_writer #(.fml_depth(FD), .idle_timeout(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .busy       (busy),
        .pipe_stb_i (pipe_stb_i),
        .pipe_ack_o (pipe_ack_o),
        .color      (color),
        .dst_addr   (dst_addr),
`ifdef TMU_BURST_WRITER_STATS_EN
        .bursts     (bursts),
        .pixels     (pixels),
`endif
        .fml_adr    (fml_adr),
        .fml_stb    (fml_stb),
        .fml_we     (fml_we),
        .fml_ack    (fml_ack),
        .fml_sel    (fml_sel),
        .fml_do     (fml_do)
    );

    typedef struct {
        logic [FD-1:0]     adr;
        logic [3:0][7:0]   sel;
        logic [3:0][63:0]  dat;
        int                ack_wait;
        int                req_delta;   // expected cycles from last accept to REQ, -1 = skip
        bit                stall_chk;   // upstream is stalled while in REQ
    } burst_t;

    burst_t exp_q[$];
    int     checks = 0, errors = 0;
    int     cyc = 0, last_acc = 0, n_pix = 0, n_bursts = 0;
    bit     mon_en = 1'b1;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic burst_t mkb(input logic [FD-1:0] adr, input logic [3:0][7:0] sel,
                                   input logic [3:0][63:0] dat, input int aw, input int rd,
                                   input bit sc);
        burst_t b;
        b.adr = adr; b.sel = sel; b.dat = dat;
        b.ack_wait = aw; b.req_delta = rd; b.stall_chk = sc;
        return b;
    endfunction

    task automatic send(input logic [FD-2:0] a, input logic [15:0] c);
        bit got;
        got = 1'b0;
        pipe_stb_i = 1'b1; dst_addr = a; color = c;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge sys_clk);
            got = pipe_ack_o;
            @(posedge sys_clk);
            #1;
        end
        pipe_stb_i = 1'b0;
        if (got) begin
            last_acc = cyc;
            n_pix++;
        end else begin
            chk("send_timeout", 64'(got), 64'd1);
        end
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge sys_clk);
            ok = !busy && exp_q.size() == 0;
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    // FML slave + monitor
    initial begin
        burst_t        b;
        logic [FD-1:0] adr0;
        logic [63:0]   m;
        forever begin
            @(negedge sys_clk);
            if (mon_en && fml_stb) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_burst", 64'(fml_adr), 64'h0);
                    mon_ack = 1'b1;
                    @(posedge sys_clk); #1 mon_ack = 1'b0;
                    repeat (4) @(negedge sys_clk);
                end else begin
                    b = exp_q.pop_front();
                    chk("burst_adr", 64'(fml_adr), 64'(b.adr));
                    if (b.req_delta >= 0)
                        chk("req_delay", 64'(cyc - last_acc), 64'(b.req_delta));
                    adr0 = fml_adr;
                    for (int w = 0; w < b.ack_wait; w++) begin
                        @(negedge sys_clk);
                        chk("req_stb_hold", 64'(fml_stb), 64'd1);
                        chk("req_adr_hold", 64'(fml_adr), 64'(adr0));
                        if (b.stall_chk) begin
                            chk("req_pipe_ack", 64'(pipe_ack_o), 64'd0);
                            chk("req_busy", 64'(busy), 64'd1);
                        end
                    end
                    mon_ack = 1'b1;
                    @(posedge sys_clk); #1 mon_ack = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge sys_clk);
                        if (k == 0) chk("stb_after_ack", 64'(fml_stb), 64'd0);
                        chk($sformatf("beat%0d_sel", k), 64'(fml_sel), 64'(b.sel[k]));
                        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{b.sel[k][i]}};
                        chk($sformatf("beat%0d_do", k), fml_do & m, b.dat[k]);
                    end
                    n_bursts++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][15:0] c;
        logic [3:0][63:0]  d;
        int                first;
        bit                seen;

        // reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stb", 64'(fml_stb), 64'd0);
        chk("rst_sel", 64'(fml_sel), 64'd0);
        chk("rst_do", fml_do, 64'd0);
        chk("rst_pipe_ack", 64'(pipe_ack_o), 64'd0);
        chk("rst_we", 64'(fml_we), 64'd1);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // full line, back-to-back, flushed by timeout
        for (int i = 0; i < 16; i++) c[i] = 16'h1000 + 16'(i) * 16'h0111;
        for (int k = 0; k < 4; k++) d[k] = {c[4*k], c[4*k+1], c[4*k+2], c[4*k+3]};
        exp_q.push_back(mkb(26'h200, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, d, 1, 8, 1'b0));
        first = 0;
        for (int i = 0; i < 16; i++) begin
            send(25'h100 + 25'(i), c[i]);
            if (i == 0) first = last_acc;
        end
        chk("throughput", 64'(last_acc - first), 64'd15);
        drain("drain_full");

        // tag miss stalls upstream until the flush completes
        exp_q.push_back(mkb(26'h200, {8'h00, 8'h00, 8'h00, 8'hC0},
                            {64'h0, 64'h0, 64'h0, 64'hAAAA_0000_0000_0000}, 1, 1, 1'b1));
        exp_q.push_back(mkb(26'h220, {8'h00, 8'h00, 8'h00, 8'hC0},
                            {64'h0, 64'h0, 64'h0, 64'hBBBB_0000_0000_0000}, 1, 8, 1'b0));
        send(25'h100, 16'hAAAA);
        send(25'h110, 16'hBBBB);
        drain("drain_miss");

        // single pixel, idle timeout
        exp_q.push_back(mkb(26'h200, {8'h00, 8'h00, 8'h30, 8'h00},
                            {64'h0, 64'h0, 64'h0000_F800_0000_0000, 64'h0}, 1, 8, 1'b0));
        send(25'h105, 16'hF800);
        drain("drain_single");

        // same-slot rewrite
        exp_q.push_back(mkb(26'h200, {8'h00, 8'h00, 8'h00, 8'hC0},
                            {64'h0, 64'h0, 64'h0, 64'h2222_0000_0000_0000}, 1, 8, 1'b0));
        send(25'h100, 16'h1111);
        send(25'h100, 16'h2222);
        drain("drain_rewrite");

        // fml_ack withheld 20 cycles with a stalled miss pending
        exp_q.push_back(mkb(26'h240, {8'h00, 8'h00, 8'h00, 8'hC0},
                            {64'h0, 64'h0, 64'h0, 64'h1234_0000_0000_0000}, 20, 1, 1'b1));
        exp_q.push_back(mkb(26'h260, {8'h00, 8'h00, 8'h00, 8'hC0},
                            {64'h0, 64'h0, 64'h0, 64'h5678_0000_0000_0000}, 1, 8, 1'b0));
        send(25'h120, 16'h1234);
        send(25'h130, 16'h5678);
        drain("drain_stall");

        // reset asserted during D1
        mon_en = 1'b0;
        send(25'h144, 16'h0F0F);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge sys_clk);
            seen = fml_stb;
        end
        chk("rst_test_req", 64'(seen), 64'd1);
        st_ack = 1'b1;
        @(posedge sys_clk); #1 st_ack = 1'b0;
        @(posedge sys_clk); #1;
        chk("d1_sel", 64'(fml_sel), 64'hC0);
        chk("d1_do", fml_do & 64'hFFFF_0000_0000_0000, 64'h0F0F_0000_0000_0000);
`ifdef TMU_BURST_WRITER_STATS_EN
        chk("stats_bursts", 64'(bursts), 64'(n_bursts));
        chk("stats_pixels", 64'(pixels), 64'(n_pix));
`endif
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_sel", 64'(fml_sel), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stb", 64'(fml_stb), 64'd0);
`ifdef TMU_BURST_WRITER_STATS_EN
        chk("midrst_bursts", 64'(bursts), 64'd0);
        chk("midrst_pixels", 64'(pixels), 64'd0);
`endif
        @(negedge sys_clk) sys_rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
